exec_alu_cc: RTL
================

Name: exec_alu_cc

Overview:
- Execute-stage ALU plus condition-code register for the Y86-64 pipeline. Sits directly upstream of the branch/cmov condition evaluator.
- Computes e_valE from the E-register operands and updates ZF/SF/OF on OPq instructions.
- Presents the registered flags as ZF_real_o/SF_real_o/OF_real_o. The evaluator combines these with E_ifun to form e_Cnd.
- CC writes are suppressed while an exception is in flight in M or W.

Parameters:
- DATA_W, 64, operand/result width
- STAT_W, 4, width of stage status codes
- SAOK, 1, status code for normal operation

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_n_i  input  1  asynchronous, active-low reset
- E_icode_i  input  4  instruction code in E
- E_ifun_i  input  4  function code in E
- E_valA_i  input  DATA_W  operand A from E register
- E_valB_i  input  DATA_W  operand B from E register
- E_valC_i  input  DATA_W  immediate/displacement from E register
- m_stat_i  input  STAT_W  status of the instruction in M
- W_stat_i  input  STAT_W  status of the instruction in W
- e_valE_o  output  DATA_W  ALU result (combinational)
- e_set_cc_o  output  1  CC write enable for this cycle (combinational)
- ZF_real_o  output  1  registered zero flag
- SF_real_o  output  1  registered sign flag
- OF_real_o  output  1  registered overflow flag

Behaviour:
- Icodes: HALT=0, NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B. Any other icode: aluA=0, aluB=0.
- aluA selection:
  - RRMOVQ, OPQ: valA
  - IRMOVQ, RMMOVQ, MRMOVQ: valC
  - CALL, PUSHQ: -8
  - RET, POPQ: +8
  - all others: 0
- aluB selection:
  - RMMOVQ, MRMOVQ, OPQ, CALL, PUSHQ, RET, POPQ: valB
  - RRMOVQ, IRMOVQ: 0
  - all others: 0
- alufun = E_ifun_i when icode=OPQ, else ADD.
- ALU functions:
  - ADD(0): B+A
  - SUB(1): B-A
  - AND(2): B&A
  - XOR(3): B^A
  - ifun>3 with OPQ: result = B+A, and CC is not written.
- Arithmetic is modulo 2^DATA_W, with no carry output.
- Flag computation, with r = result:
  - ZF = (r==0)
  - SF = r[DATA_W-1]
  - OF for ADD = (A<0)==(B<0) && (r<0)!=(A<0)
  - OF for SUB = (A<0)!=(B<0) && (r<0)!=(B<0)
  - OF for AND/XOR = 0
- e_set_cc_o = (icode==OPQ) && (ifun<=3) && (m_stat_i==SAOK) && (W_stat_i==SAOK).
- CC register:
  - On the rising edge with e_set_cc_o=1, load the computed {ZF,SF,OF}; otherwise hold.
  - Latency: 1 cycle. An OPq in E at cycle n makes its flags visible on *_real_o from cycle n+1, so the JXX/CMOVXX that follows directly in E sees them without forwarding.
- Reset: while rst_n_i=0, and asynchronously on assertion, ZF=1, SF=0, OF=0. e_valE_o and e_set_cc_o are combinational and follow their inputs during reset. Reset mid-operation discards any pending CC write.
- Exception gating: if M or W holds a non-SAOK status (ADR/INS/HLT), the OPq in E must not alter CC. This preserves the programmer-visible state at the faulting instruction.
- Bubbles arrive as icode=NOP, so no CC write occurs.
- Back-to-back OPqs update CC every cycle; the last writer wins.
- No stall input: the CC is never frozen except by the exception gating above.

Test Plan:
- Reset: assert rst_n_i=0 asynchronously mid-cycle -> ZF_real_o=1, SF_real_o=0, OF_real_o=0 immediately; hold for 3 cycles with OPQ inputs -> flags unchanged.
- OPQ SUB, valA=5, valB=5, stats=SAOK -> e_valE_o=0, e_set_cc_o=1; next cycle Z=1, S=0, O=0. Then ADD with valA=1, valB=0x7FFF_FFFF_FFFF_FFFF -> e_valE_o=0x8000_0000_0000_0000; next cycle Z=0, S=1, O=1.
- OPQ SUB, valA=1, valB=0x8000_0000_0000_0000 -> e_valE_o=0x7FFF_FFFF_FFFF_FFFF; next cycle O=1, S=0. Then XOR, valA=valB=0xFF -> Z=1, O=0.
- Exception gating: OPQ ADD with a zero result while m_stat_i=3 (INS), then while W_stat_i=4 (HLT) -> e_set_cc_o=0 and flags retain their prior values. Clear both stats to SAOK -> the next OPQ updates the flags.
- Address arithmetic:
  - PUSHQ, valB=0x100 -> e_valE_o=0xF8
  - POPQ -> 0x108
  - MRMOVQ, valC=0x10, valB=0x20 -> 0x30
  - IRMOVQ, valC=0x2A -> 0x2A
  - In all four cases e_set_cc_o=0 and the flags are unchanged.
- Invalid OPQ ifun=7 -> e_valE_o=B+A, e_set_cc_o=0, no flag change. Back-to-back OPQs (SUB 3-3 then AND 1&2) -> Z=1 after the first edge and remains Z=1 after the second.

Source files
------------

// File: rtl/exec_alu_cc.sv
// Y86-64 execute stage: operand select, ALU and ZF/SF/OF condition-code register.
// e_valE_o/e_set_cc_o are combinational; flags register in 1 cycle; no backpressure, CC frozen only by M/W exceptions.
module exec_alu_cc #(
  parameter int                DATA_W = 64,
  parameter int                STAT_W = 4,
  parameter logic [STAT_W-1:0] SAOK   = STAT_W'(1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [3:0]        E_icode_i,
  input  logic [3:0]        E_ifun_i,
  input  logic [DATA_W-1:0] E_valA_i,
  input  logic [DATA_W-1:0] E_valB_i,
  input  logic [DATA_W-1:0] E_valC_i,
  input  logic [STAT_W-1:0] m_stat_i,
  input  logic [STAT_W-1:0] W_stat_i,
  output logic [DATA_W-1:0] e_valE_o,
  output logic              e_set_cc_o,
  output logic              ZF_real_o,
  output logic              SF_real_o,
  output logic              OF_real_o
);

  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  logic [DATA_W-1:0] w_alu_a;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_res;
  logic [3:0]        w_alufun;
  logic              w_sa;
  logic              w_sb;
  logic              w_sr;
  logic              w_zf;
  logic              w_sf;
  logic              w_of;
  logic              r_zf;
  logic              r_sf;
  logic              r_of;

  always_comb begin
    w_alu_a = '0;
    case (E_icode_i)
      I_RRMOVQ, I_OPQ:              w_alu_a = E_valA_i;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_alu_a = E_valC_i;
      I_CALL, I_PUSHQ:              w_alu_a = -(DATA_W'(8));
      I_RET, I_POPQ:                w_alu_a = DATA_W'(8);
      default:                      w_alu_a = '0;
    endcase
  end

  always_comb begin
    w_alu_b = '0;
    case (E_icode_i)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: w_alu_b = E_valB_i;
      default:                                                   w_alu_b = '0;
    endcase
  end

  assign w_alufun = (E_icode_i == I_OPQ) ? E_ifun_i : A_ADD;

  // Undefined OPq functions fall back to ADD; e_set_cc_o keeps them off the CC.
  always_comb begin
    w_res = '0;
    case (w_alufun)
      A_SUB:   w_res = w_alu_b - w_alu_a;
      A_AND:   w_res = w_alu_b & w_alu_a;
      A_XOR:   w_res = w_alu_b ^ w_alu_a;
      default: w_res = w_alu_b + w_alu_a;
    endcase
  end

  assign w_sa = w_alu_a[DATA_W-1];
  assign w_sb = w_alu_b[DATA_W-1];
  assign w_sr = w_res[DATA_W-1];
  assign w_zf = (w_res == '0);
  assign w_sf = w_sr;

  always_comb begin
    w_of = 1'b0;
    case (w_alufun)
      A_SUB:        w_of = (w_sa != w_sb) && (w_sr != w_sb);
      A_AND, A_XOR: w_of = 1'b0;
      default:      w_of = (w_sa == w_sb) && (w_sr != w_sa);
    endcase
  end

  assign e_valE_o   = w_res;
  assign e_set_cc_o = (E_icode_i == I_OPQ) && (E_ifun_i <= A_XOR) &&
                      (m_stat_i == SAOK) && (W_stat_i == SAOK);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (e_set_cc_o) begin
      r_zf <= w_zf;
      r_sf <= w_sf;
      r_of <= w_of;
    end
  end

  assign ZF_real_o = r_zf;
  assign SF_real_o = r_sf;
  assign OF_real_o = r_of;

endmodule
